seq_divider: RTL and testbench



---
 rtl/arith_pkg.sv | 18 +
 rtl/div_step.sv | 31 +++
 rtl/seq_divider.sv | 111 +++++++++++
 tb/tb_seq_divider.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic datapath package: FSM state encoding for the sequential
// divider, the default operand width (shared with the array multiplier), and
// the quotient value reported on a divide by zero.
package arith_pkg;

    // Default operand width for the multiplier/divider pair.
    localparam int ARITH_W = 4;

    // Divide-by-zero quotient is all ones; consumers slice [W-1:0].
    localparam logic [63:0] DIV0_QUOT = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step (combinational).
// Ports:
//   r      : partial remainder, W+1 bits (top bit is always 0 between steps)
//   q      : working dividend/quotient shift register, W bits
//   d      : divisor, W bits
//   r_next : partial remainder after shift, trial subtract and restore
//   q_next : q shifted left with the new quotient bit in bit 0
module div_step #(
    parameter int W = 4
) (
    input  logic [W:0]   r,
    input  logic [W-1:0] q,
    input  logic [W-1:0] d,
    output logic [W:0]   r_next,
    output logic [W-1:0] q_next
);

    logic [W+1:0] shifted;
    logic [W+1:0] trial;
    logic         borrow;

    // Shift {R,Q} left by one. The full R is carried so the subtract stays
    // exact; since R < D between steps the extra top bit is always zero.
    assign shifted = {r, q[W-1]};
    assign trial   = shifted - {2'b00, d};
    assign borrow  = trial[W+1];

    assign r_next = borrow ? shifted[W:0] : trial[W:0];
    assign q_next = {q[W-2:0], ~borrow};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : request pulse, sampled only while idle
//   dividend, divisor : W-bit unsigned operands, captured on accepted start
//   busy              : high while an operation is in CALC or DONE
//   done              : one-cycle pulse when results are valid
//   quotient          : W-bit quotient, held until the next result
//   remainder         : W-bit remainder, held until the next result
//   div_by_zero       : set with done when the divisor was zero
module seq_divider
    import arith_pkg::*;
#(
    parameter  int W  = ARITH_W,
    localparam int CW = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    div_state_e   state, state_nxt;
    logic [W:0]   r_q, r_nx;
    logic [W-1:0] q_q, q_nx;
    logic [W-1:0] d_q;
    logic [CW-1:0] cnt;
    logic         last_step;

    assign last_step = (cnt == CW'(1));

    div_step #(.W(W)) u_step (
        .r      (r_q),
        .q      (q_q),
        .d      (d_q),
        .r_next (r_nx),
        .q_next (q_nx)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = (divisor == '0) ? S_DONE : S_CALC;
            S_CALC: if (last_step) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    // Datapath, counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            // Skip CALC entirely; results go straight out.
                            quotient    <= DIV0_QUOT[W-1:0];
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            q_q         <= dividend;
                            r_q         <= '0;
                            d_q         <= divisor;
                            cnt         <= CW'(W);
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                S_CALC: begin
                    r_q <= r_nx;
                    q_q <= q_nx;
                    cnt <= cnt - CW'(1);
                    if (last_step) begin
                        quotient  <= q_nx;
                        remainder <= r_nx[W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    localparam int W = 4;
    localparam int QMAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    seq_divider #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int dz;
        int edge_n;  // posedge index after which done must be high
        bit b2b;     // issued back-to-back with the previous op
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   free_at = 0;      // first posedge index at which the DUT accepts
    int   last_done = -1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever done is seen.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("done_edge", cyc, e.edge_n);
                chk("quotient", int'(quotient), e.q);
                chk("remainder", int'(remainder), e.r);
                chk("div_by_zero", int'(div_by_zero), e.dz);
                if (e.b != 0) begin
                    chk("recompose", int'(quotient) * e.b + int'(remainder), e.a);
                    chk("rem_lt_div", int'(int'(remainder) < e.b), 1);
                end
                // one DONE cycle + one IDLE cycle + W CALC cycles (none on /0)
                if (e.b2b && last_done >= 0)
                    chk("done_spacing", cyc - last_done, 2 + ((e.b != 0) ? W : 0));
            end
            last_done = cyc;
        end else if (sb.size() > 0 && cyc > sb[0].edge_n) begin
            chk("missed_done", cyc, sb[0].edge_n);
            void'(sb.pop_front());
        end
    end

    // Called #1 after a posedge. Waits until the DUT is idle at the next
    // edge, presents the operands, and records the expected result.
    task automatic issue(input int a, input int b, input bit hold, input bit b2b);
        exp_t e;
        while (cyc + 1 < free_at) begin
            @(posedge clk); #1;
        end
        dividend = W'(a);
        divisor  = W'(b);
        start    = 1'b1;
        @(posedge clk); #1;
        e.a      = a;
        e.b      = b;
        e.q      = (b == 0) ? QMAX : a / b;
        e.r      = (b == 0) ? a : a % b;
        e.dz     = (b == 0) ? 1 : 0;
        e.edge_n = cyc + ((b != 0) ? W : 0);
        e.b2b    = b2b;
        sb.push_back(e);
        free_at  = e.edge_n + 2;
        // Captured copies must be used, so scramble the live inputs.
        dividend = W'($urandom);
        divisor  = W'($urandom);
        if (!hold) start = 1'b0;
    endtask

    task automatic step_to(input int n);
        while (cyc < n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int acc;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_dbz", int'(div_by_zero), 0);
        free_at = cyc + 1;

        // Basic 13/3
        issue(13, 3, 1'b0, 1'b0);
        chk("busy_after_start", int'(busy), 1);
        step_to(free_at - 1);
        chk("busy_after_done", int'(busy), 0);

        // Boundaries
        issue(15, 1, 1'b0, 1'b0);
        issue(2, 7, 1'b0, 1'b0);
        issue(15, 15, 1'b0, 1'b0);
        issue(0, 5, 1'b0, 1'b0);

        // Divide by zero, then a normal op
        issue(5, 0, 1'b0, 1'b0);
        chk("dbz_done_next", int'(done), 1);
        issue(9, 2, 1'b0, 1'b0);

        // Start while busy: requests during CALC and DONE are ignored
        issue(13, 3, 1'b0, 1'b0);
        acc = cyc;
        dividend = 4'd6;
        divisor  = 4'd2;
        start    = 1'b1;
        step_to(acc + W + 1);
        start = 1'b0;

        // Reset on the 2nd CALC cycle of 14/3
        issue(14, 3, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        void'(sb.pop_back());
        @(posedge clk); #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_quotient", int'(quotient), 0);
        chk("midrst_remainder", int'(remainder), 0);
        rst = 1'b0;
        free_at = cyc + 1;
        issue(14, 3, 1'b0, 1'b0);

        // Random operations
        for (int i = 0; i < 40; i++)
            issue(int'($urandom_range(0, QMAX)),
                  ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, QMAX)),
                  1'($urandom_range(0, 1)), 1'b0);

        // Exhaustive sweep, start held high back-to-back
        for (int a = 0; a <= QMAX; a++)
            for (int b = 0; b <= QMAX; b++)
                issue(a, b, 1'b1, !(a == 0 && b == 0));
        start = 1'b0;

        for (int i = 0; i < 50 && sb.size() > 0; i++) begin
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
